regfile_sb: RTL and testbench

- Parametrised successor to the CPU register file: N_RD asynchronous read ports, one synchronous write port, hardwired zero register.
- Adds write-to-read bypass, a per-register pending-write scoreboard for the pipeline's hazard logic, and a sequential clear engine.
- Sits in the decode stage. The datapath reads operands here; the hazard unit stalls on rd_ready.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default widths and slicing helper for the register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    // LSB of field idx in a flattened vector of w-bit fields.
    function automatic int lsb_of(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback or by the clear sweep. Produces per-port operand-ready flags.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,     // qualified writeback (IDLE, addr != 0)
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,    // qualified issue (IDLE)
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     swp_en,    // clear sweep active
    input  logic [ADDR_W-1:0]        swp_addr,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD-1:0]          rd_ready
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending, pend_nxt;

    // Next pending bits: sweep clears, then issue sets (new producer wins
    // over a same-edge writeback), then writeback clears. Bit 0 never pends.
    always_comb begin
        pend_nxt = pending;
        for (int j = 1; j < NREG; j++) begin
            if (swp_en && swp_addr == ADDR_W'(j))
                pend_nxt[j] = 1'b0;
            else if (iss_en && iss_addr == ADDR_W'(j))
                pend_nxt[j] = 1'b1;
            else if (wr_en && wr_addr == ADDR_W'(j))
                pend_nxt[j] = 1'b0;
        end
        pend_nxt[0] = 1'b0;
    end

    // Pending-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pend_nxt;
    end

    // Ready per port: r0 is always ready; a writeback completing this cycle
    // to the read address counts as ready when forwarding is enabled.
    for (genvar i = 0; i < N_RD; i++) begin : g_rdy
        logic [ADDR_W-1:0] a;
        assign a = ra[lsb_of(i, ADDR_W) +: ADDR_W];
        assign rd_ready[i] = (a == '0) || !pending[a] ||
                             ((BYPASS != 0) && wr_en && (wr_addr == a));
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with N_RD async read ports, one sync write port, hardwired
// r0, write-to-read bypass, pending-write scoreboard and a clear engine.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic [N_RD-1:0]          rd_ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int NREG = 1 << ADDR_W;

    rf_state_e                   state, state_nxt;
    logic [ADDR_W-1:0]           cnt;
    logic                        sweep;
    logic                        idle;
    logic                        wr_en;
    logic                        iss_en;
    logic [NREG-1:0][DATA_W-1:0] regs;

    // Writes and issues only count in IDLE; during the sweep they are dropped.
    assign idle   = (state == IDLE);
    assign wr_en  = idle && we && (wa != '0);
    assign iss_en = idle && issue_en && (issue_addr != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: sweep runs from r1 up to the last register, no restart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy  = (state == CLEAR);
        sweep = (state == CLEAR);
    end

    // Sweep pointer: sits at 1 while idle; exit tested on all-ones before
    // the increment so it never needs to pass through 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= ADDR_W'(1);
        else if (sweep)
            cnt <= (cnt == '1) ? ADDR_W'(1) : cnt + ADDR_W'(1);
        else if (clr_req)
            cnt <= ADDR_W'(1);
    end

    // Storage: sweep zeroes one register per cycle, else normal writeback.
    // r0 is never a target, so it holds its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     regs <= '0;
        else if (sweep) regs[cnt] <= '0;
        else if (wr_en) regs[wa] <= wd;
    end

    // Read muxes with optional same-cycle forwarding of write data.
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = ra[lsb_of(i, ADDR_W) +: ADDR_W];
        assign rd[i*DATA_W +: DATA_W] =
            (a == '0)                                  ? '0 :
            ((BYPASS != 0) && wr_en && (wa == a))      ? wd :
                                                         regs[a];
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_RD   (N_RD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wa),
        .iss_en   (iss_en),
        .iss_addr (issue_addr),
        .swp_en   (sweep),
        .swp_addr (cnt),
        .ra       (ra),
        .rd_ready (rd_ready)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 4-port forwarding instance and a 2-port
// non-forwarding instance share stimulus and are compared to an array model.
module tb_regfile_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 4;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            we = 1'b0, issue_en = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]   wa = '0, issue_addr = '0;
    logic [DW-1:0]   wd = '0;
    logic [NR*AW-1:0] ra = '0;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]   rdy;
    logic            busy;
    logic [2*DW-1:0] rd_nb;
    logic [1:0]      rdy_nb;
    logic            busy_nb;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_ready(rdy),
        .we(we), .wa(wa), .wd(wd), .issue_en(issue_en), .issue_addr(issue_addr),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra[2*AW-1:0]), .rd(rd_nb), .rd_ready(rdy_nb),
        .we(we), .wa(wa), .wd(wd), .issue_en(issue_en), .issue_addr(issue_addr),
        .clr_req(clr_req), .busy(busy_nb)
    );

    // Reference model
    logic [DW-1:0] mem [NREG];
    bit            pend [NREG];
    bit            clearing;
    int            ccnt;
    int            nvec = 0;
    int            nbad = 0;

    task automatic chk(input string tag, input int port, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s[%0d]: observed %h, expected %h", tag, port, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) begin
            mem[k]  = '0;
            pend[k] = 1'b0;
        end
        clearing = 1'b0;
        ccnt     = 1;
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && !clearing && we && wa == a) return wd;
        return mem[a];
    endfunction

    function automatic logic m_rdy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b1;
        if (byp && !clearing && we && wa == a) return 1'b1;
        return !pend[a];
    endfunction

    // Effect of one rising edge on the model, from the inputs held across it.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (clearing) begin
            mem[ccnt]  = '0;
            pend[ccnt] = 1'b0;
            if (ccnt == NREG - 1) clearing = 1'b0;
            else                  ccnt++;
        end else begin
            if (we && wa != 0) begin
                mem[wa]  = wd;
                pend[wa] = 1'b0;
            end
            if (issue_en && issue_addr != 0) pend[issue_addr] = 1'b1;
            if (clr_req) begin
                clearing = 1'b1;
                ccnt     = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) begin
            a = ra[i*AW +: AW];
            chk("rd", i, rd[i*DW +: DW], m_rd(a, 1'b1));
            chk("rdy", i, DW'(rdy[i]), DW'(m_rdy(a, 1'b1)));
        end
        for (int i = 0; i < 2; i++) begin
            a = ra[i*AW +: AW];
            chk("rd_nobyp", i, rd_nb[i*DW +: DW], m_rd(a, 1'b0));
            chk("rdy_nobyp", i, DW'(rdy_nb[i]), DW'(m_rdy(a, 1'b0)));
        end
        chk("busy", 0, DW'(busy), DW'(clearing));
        chk("busy_nobyp", 0, DW'(busy_nb), DW'(clearing));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, a1, a2, a3);
        ra = {a3, a2, a1, a0};
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state, including with nonzero read addresses
        #1 check_all();
        set_ra(5'd9, 5'd7, 5'd5, 5'd3);
        #1 check_all();
        chk("reset_rdy", 0, DW'(rdy), DW'(4'hf));
        @(negedge clk);
        rst_n = 1'b1;

        // Write r5, read back next cycle
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        cyc();
        we = 1'b0; set_ra(5'd5, 5'd5, 5'd0, 5'd0);
        #1 chk("r5", 0, rd[31:0], 32'hDEADBEEF);
        chk("r5_nobyp", 1, rd_nb[63:32], 32'hDEADBEEF);
        cyc();

        // Write to r0 is dropped
        we = 1'b1; wa = 5'd0; wd = 32'h1234; set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        cyc();
        we = 1'b0;
        #1 chk("r0", 0, rd[31:0], 32'h0);
        cyc();

        // Bypass: r7 holds 0x77, same-cycle write of A5A5A5A5 read on port 1
        we = 1'b1; wa = 5'd7; wd = 32'h77;
        cyc();
        wd = 32'hA5A5A5A5; set_ra(5'd0, 5'd7, 5'd0, 5'd0);
        #1 chk("byp_rd", 1, rd[63:32], 32'hA5A5A5A5);
        chk("byp_rdy", 1, DW'(rdy[1]), 32'd1);
        chk("nobyp_old", 1, rd_nb[63:32], 32'h77);
        cyc();
        we = 1'b0;

        // Scoreboard on r9
        issue_en = 1'b1; issue_addr = 5'd9;
        cyc();
        issue_en = 1'b0; set_ra(5'd9, 5'd9, 5'd0, 5'd0);
        #1 chk("pend9", 0, DW'(rdy[0]), 32'd0);
        cyc();
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        #1 chk("wb9_byp_rdy", 0, DW'(rdy[0]), 32'd1);
        chk("wb9_nobyp_rdy", 0, DW'(rdy_nb[0]), 32'd0);
        cyc();
        we = 1'b0;
        #1 chk("rdy9_after_wb", 0, DW'(rdy[0]), 32'd1);
        cyc();
        we = 1'b1; issue_en = 1'b1; wd = 32'h999;
        cyc();
        we = 1'b0; issue_en = 1'b0;
        #1 chk("set_wins", 1, DW'(rdy_nb[1]), 32'd0);
        cyc();

        // Four simultaneous reads including r0 while r0 is issued
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        cyc();
        we = 1'b0; issue_en = 1'b1; issue_addr = 5'd0; set_ra(5'd0, 5'd5, 5'd7, 5'd9);
        #1 chk("q4_rdy", 0, DW'(rdy), 32'hf);
        chk("q4_rd", 3, rd[127:96], 32'h99);
        cyc();
        issue_en = 1'b0;
        #1 chk("q4_rdy_after", 0, DW'(rdy), 32'hf);
        cyc();

        // Fill r1..r31 with their index, then clear
        for (int k = 1; k < NREG; k++) begin
            we = 1'b1; wa = AW'(k); wd = DW'(k);
            cyc();
        end
        we = 1'b0; set_ra(5'd3, 5'd31, 5'd1, 5'd20);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            we       = (k == 5);
            wa       = 5'd3;
            wd       = 32'h55;
            clr_req  = (k == 8);
            if (busy === 1'b1) n++;
            cyc();
        end
        we = 1'b0; clr_req = 1'b0;
        chk("busy_len", 0, DW'(n), 32'd31);
        #1 chk("r3_after_clr", 0, rd[31:0], 32'h0);
        chk("r31_after_clr", 1, rd[63:32], 32'h0);
        cyc();

        // Reset in the middle of a clear
        we = 1'b1; wa = 5'd20; wd = 32'h20;
        cyc();
        we = 1'b0; issue_en = 1'b1; issue_addr = 5'd21; set_ra(5'd20, 5'd21, 5'd0, 5'd20);
        cyc();
        issue_en = 1'b0; clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (9) cyc();
        rst_n = 1'b0;
        model_reset();
        #1 chk("rst_busy", 0, DW'(busy), 32'd0);
        chk("rst_r20", 0, rd[31:0], 32'h0);
        chk("rst_rdy", 0, DW'(rdy), 32'hf);
        cyc();
        rst_n = 1'b1;
        cyc();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b1) n++;
            cyc();
        end
        chk("busy_len_again", 0, DW'(n), 32'd31);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            bit do_rst;
            do_rst     = ($urandom_range(0, 199) == 0);
            we         = do_rst ? 1'b0 : 1'($urandom_range(0, 1));
            wa         = AW'($urandom_range(0, 31));
            wd         = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = AW'($urandom_range(0, 31));
            clr_req    = ($urandom_range(0, 63) == 0);
            ra         = NR*AW'($urandom);
            if (k % 4 == 0) ra[AW-1:0] = wa;
            if (do_rst) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            cyc();
        end
        rst_n = 1'b1; we = 1'b0; issue_en = 1'b0; clr_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
